// File: rtl/comparador_pkg.sv
// Shared types and width helpers for the chunk-serial comparator.
package comparador_pkg;

  typedef enum logic {IDLE, SCAN} state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Count must reach NCHUNK itself, hence the +1.
  function automatic int cnt_w_of(input int width, input int chunk);
    return clog2(width / chunk + 1);
  endfunction

endpackage

// File: rtl/comparador_seq_chunk_cmp.sv
// Combinational compare of one CHUNK-bit slice, sign-aware on the MSB chunk.
module chunk_cmp
  import comparador_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  input  logic             is_msb,
  input  logic             signed_mode,
  output logic             c_eq,
  output logic             c_lt,
  output logic             c_gt
);

  logic sign_split;

  // Differing sign bits invert the unsigned ordering, so decide on sign alone.
  assign sign_split = signed_mode && is_msb && (a_c[CHUNK-1] != b_c[CHUNK-1]);

  always_comb begin
    c_eq = 1'b0;
    c_lt = 1'b0;
    c_gt = 1'b0;
    if (sign_split) begin
      c_lt = a_c[CHUNK-1];
      c_gt = b_c[CHUNK-1];
    end else begin
      c_eq = (a_c == b_c);
      c_lt = (a_c < b_c);
      c_gt = (a_c > b_c);
    end
  end

endmodule

// File: rtl/comparador_seq.sv
// Multi-cycle magnitude comparator: scans operands MSB chunk first and stops
// at the first differing chunk, reporting eq/lt/gt with a start/busy/done handshake.
module comparador_seq
  import comparador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  localparam int NCHUNK = nchunk_of(WIDTH, CHUNK),
  localparam int CNT_W  = cnt_w_of(WIDTH, CHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [CNT_W-1:0] chunks
);

  localparam int IDX_W = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sm_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               eq_q;
  logic               lt_q;
  logic               gt_q;
  logic [CNT_W-1:0]   chunks_q;

  logic [CHUNK-1:0]   a_ch [NCHUNK];
  logic [CHUNK-1:0]   b_ch [NCHUNK];
  logic               is_msb;
  logic               c_eq;
  logic               c_lt;
  logic               c_gt;
  logic [CNT_W-1:0]   chunks_d;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  assign is_msb   = (idx_q == IDX_W'(NCHUNK - 1));
  assign chunks_d = CNT_W'(NCHUNK) - CNT_W'(idx_q);

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a_c         (a_ch[idx_q]),
    .b_c         (b_ch[idx_q]),
    .is_msb      (is_msb),
    .signed_mode (sm_q),
    .c_eq        (c_eq),
    .c_lt        (c_lt),
    .c_gt        (c_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sm_q     <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      chunks_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            sm_q     <= signed_mode;
            idx_q    <= IDX_W'(NCHUNK - 1);
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            chunks_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (!c_eq) begin
            lt_q     <= c_lt;
            gt_q     <= c_gt;
            chunks_q <= chunks_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else if (idx_q == '0) begin
            eq_q     <= 1'b1;
            chunks_q <= CNT_W'(NCHUNK);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign eq     = eq_q;
  assign lt     = lt_q;
  assign gt     = gt_q;
  assign chunks = chunks_q;

endmodule

// File: tb/tb_comparador_seq.sv
// Directed-vector bench for comparador_seq (WIDTH=8, CHUNK=2).
module tb_comparador_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic       eq;
  logic       lt;
  logic       gt;
  logic [2:0] chunks;

  int checks = 0;
  int errors = 0;

  comparador_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .lt          (lt),
    .gt          (gt),
    .chunks      (chunks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic e, input logic l,
                              input logic g, input int c);
    check({tag, "_eq"}, 32'(eq), 32'(e));
    check({tag, "_lt"}, 32'(lt), 32'(l));
    check({tag, "_gt"}, 32'(gt), 32'(g));
    check({tag, "_chunks"}, 32'(chunks), 32'(c));
  endtask

  // Called one negedge after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic sm, input logic e, input logic l, input logic g,
                     input int c);
    int lat;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(c));
    check_result(tag, e, l, g, c);
    $display("txn %s a=%02h b=%02h signed=%0d -> eq=%0d lt=%0d gt=%0d chunks=%0d lat=%0d",
             tag, av, bv, sm, eq, lt, gt, chunks, lat);
  endtask

  // One cycle later: done has dropped and the result is held.
  task automatic check_hold(input string tag, input logic e, input logic l,
                            input logic g, input int c);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check_result({tag, "_hold"}, e, l, g, c);
  endtask

  initial begin
    int lat;
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst", 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("ff_00", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    check_hold("ff_00", 1'b0, 1'b0, 1'b1, 1);
    run("5a_5a", 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    check_hold("5a_5a", 1'b1, 1'b0, 1'b0, 4);
    run("00_00", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    run("ffs_ff", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    run("12_13", 8'h12, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    run("13_12", 8'h13, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    run("80_01_s", 8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run("80_01_u", 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    run("fe_ff_s", 8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    run("01_80_s", 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    check_hold("01_80_s", 1'b0, 1'b0, 1'b1, 1);

    // Start held high with new operands while busy must be ignored.
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    check("ign_busy", 32'(busy), 32'd1);
    a = 8'hFF; b = 8'h00; signed_mode = 1'b1;
    wait_done("ign", lat);
    start = 1'b0;
    check("ign_latency", 32'(lat), 32'd4);
    check_result("ign", 1'b0, 1'b1, 1'b0, 4);
    $display("txn ign a=12 b=13 (busy-time start ignored) -> lt=%0d chunks=%0d", lt, chunks);
    check_hold("ign", 1'b0, 1'b1, 1'b0, 4);

    // Back-to-back: new start issued during the done cycle.
    run("b2b_first", 8'h33, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    a = 8'h40; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_nodone", 32'(done), 32'd0);
    check_result("b2b_clear", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_idle", 32'(busy), 32'd0);
    check_result("b2b", 1'b0, 1'b0, 1'b1, 1);
    $display("txn b2b a=40 b=00 -> gt=%0d chunks=%0d", gt, chunks);
    @(negedge clk);

    // Reset during the second SCAN cycle aborts with no done.
    a = 8'h33; b = 8'h33; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_result("abort", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_still_idle", 32'(busy), 32'd0);
    $display("txn abort a=33 b=33 reset mid-scan -> busy=%0d done_pulses=%0d", busy, done_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
